// File: rtl/eic_prio_scheduler_if.sv
// Peripheral bus bundle for the external-interrupt priority scheduler.
// Bus width and access-size encodings are shared by every user of this bus.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

interface eic_prio_scheduler_if;
  logic [3:0]                  addr;
  logic                        w_rb;
  logic [`BUS_ACC_WIDTH-1:0]   acc;
  logic [`BUS_WIDTH-1:0]       rdata;
  logic [`BUS_WIDTH-1:0]       wdata;
  logic                        req;
  logic                        resp;
  logic                        fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );
endinterface

// File: rtl/eic_prio_scheduler.sv
// Edge-latched, enable-masked interrupt sources arbitrated by programmable priority
// and presented to the core as one trigger with a trigger/handled handshake.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module eic_prio_scheduler #(
  parameter int unsigned SRC_NUM = 8,
  parameter int unsigned PRIO_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SRC_NUM-1:0]   ext_int_from,
  output logic                 ext_int_trigger,
  input  logic                 ext_int_handled,
  eic_prio_scheduler_if.slave  bus
);

  localparam int unsigned ID_W      = 4;
  localparam int unsigned PRIO_BITS = SRC_NUM * PRIO_W;
  localparam int unsigned BW        = `BUS_WIDTH;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_EN    = 2'd1;
  localparam logic [1:0] REG_PRIO  = 2'd2;
  localparam logic [1:0] REG_CLAIM = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    SIGNAL = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SRC_NUM-1:0]   pending;
  logic [SRC_NUM-1:0]   pending_next;
  logic [SRC_NUM-1:0]   enable;
  logic [SRC_NUM-1:0]   prev;
  logic [PRIO_BITS-1:0] prio;
  logic [ID_W-1:0]      win_id;

  logic [SRC_NUM-1:0]   pulse;
  logic [SRC_NUM-1:0]   elig;
  logic [SRC_NUM-1:0]   win_mask;
  logic [SRC_NUM-1:0]   w1c_mask;
  logic [SRC_NUM-1:0]   hnd_mask;
  logic [ID_W-1:0]      arb_id;
  logic [PRIO_W-1:0]    best_prio;
  logic                 found;
  logic                 trigger_next;
  logic                 latch_win;
  logic                 handled_clr;

  logic                 legal;
  logic                 wr_en;
  logic                 rd_en;
  logic [BW-1:0]        rd_mux;
  logic                 unused_wdata;

  assign pulse    = ext_int_from & ~prev;
  assign elig     = pending & enable;
  assign win_mask = SRC_NUM'(1'b1) << win_id;

  // Highest priority wins; strict compare keeps the lowest index on ties.
  always_comb begin
    arb_id    = '0;
    best_prio = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < SRC_NUM; i++) begin
      if (elig[i] && (!found || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
        found     = 1'b1;
        best_prio = prio[i*PRIO_W +: PRIO_W];
        arb_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_next   = state;
    trigger_next = 1'b0;
    latch_win    = 1'b0;
    handled_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) state_next = ARB;
      end
      ARB: begin
        if (|elig) begin
          latch_win    = 1'b1;
          trigger_next = 1'b1;
          state_next   = SIGNAL;
        end else begin
          state_next = IDLE;
        end
      end
      SIGNAL: begin
        if (ext_int_handled) begin
          handled_clr = 1'b1;
          state_next  = IDLE;
        end else if (!(|(pending & win_mask)) || !(|(enable & win_mask))) begin
          // Software withdrew the winner before the core acknowledged it.
          state_next = IDLE;
        end else begin
          trigger_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus decode: only aligned word accesses are legal, and CLAIM is read-only.
  assign legal = (bus.acc == `BUS_ACC_4B) && (bus.addr[1:0] == 2'b00) &&
                 !(bus.w_rb && (bus.addr[3:2] == REG_CLAIM));
  assign bus.fault = bus.req && !legal;
  assign wr_en     = bus.req && legal && bus.w_rb;
  assign rd_en     = bus.req && legal && !bus.w_rb;

  assign w1c_mask = (wr_en && (bus.addr[3:2] == REG_PEND)) ? bus.wdata[SRC_NUM-1:0] : '0;
  assign hnd_mask = handled_clr ? win_mask : '0;
  // A new edge on a source beats any clear landing in the same cycle.
  assign pending_next = (pending & ~(w1c_mask | hnd_mask)) | pulse;

  always_comb begin
    rd_mux = '0;
    case (bus.addr[3:2])
      REG_PEND:  rd_mux = BW'(pending);
      REG_EN:    rd_mux = BW'(enable);
      REG_PRIO:  rd_mux = BW'(prio);
      REG_CLAIM: begin
        rd_mux[BW-1]     = (state == SIGNAL);
        rd_mux[ID_W-1:0] = win_id;
      end
      default:   rd_mux = '0;
    endcase
  end

  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev            <= '0;
      pending         <= '0;
      enable          <= '0;
      prio            <= '0;
      win_id          <= '0;
      ext_int_trigger <= 1'b0;
      bus.resp        <= 1'b0;
      bus.rdata       <= '0;
    end else begin
      prev            <= ext_int_from;
      pending         <= pending_next;
      ext_int_trigger <= trigger_next;
      bus.resp        <= bus.req && legal;
      if (latch_win) win_id <= arb_id;
      if (wr_en && (bus.addr[3:2] == REG_EN))   enable <= bus.wdata[SRC_NUM-1:0];
      if (wr_en && (bus.addr[3:2] == REG_PRIO)) prio   <= bus.wdata[PRIO_BITS-1:0];
      if (rd_en) bus.rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_eic_prio_scheduler.sv
// Directed bench for eic_prio_scheduler: bus reads are scored against a queue of
// expected values; trigger timing is checked cycle by cycle.

`timescale 1ns/1ps

module tb_eic_prio_scheduler;

  localparam logic [3:0] A_PEND  = 4'h0;
  localparam logic [3:0] A_EN    = 4'h4;
  localparam logic [3:0] A_PRIO  = 4'h8;
  localparam logic [3:0] A_CLAIM = 4'hC;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] from;
  logic       trig;
  logic       handled;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  eic_prio_scheduler_if bus ();

  eic_prio_scheduler #(.SRC_NUM(8), .PRIO_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .ext_int_from    (from),
    .ext_int_trigger (trig),
    .ext_int_handled (handled),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.req   = 1'b0;
    bus.w_rb  = 1'b0;
    bus.acc   = `BUS_ACC_4B;
    bus.addr  = 4'h0;
    bus.wdata = 32'h0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.w_rb  = 1'b1;
    bus.acc   = `BUS_ACC_4B;
    bus.wdata = d;
    bus.req   = 1'b1;
    #1 check("wr_fault", 32'(bus.fault), 32'h0);
    tick();
    bus_idle();
    check("wr_resp", 32'(bus.resp), 32'h1);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    bus.addr = a;
    bus.w_rb = 1'b0;
    bus.acc  = `BUS_ACC_4B;
    bus.req  = 1'b1;
    #1 check("rd_fault", 32'(bus.fault), 32'h0);
    tick();
    bus_idle();
    check("rd_resp", 32'(bus.resp), 32'h1);
    check(tag, bus.rdata, exp_q.pop_front());
  endtask

  task automatic bus_fault(input logic [3:0] a, input logic w, input logic [1:0] acc,
                           input logic [31:0] d, input string tag);
    bus.addr  = a;
    bus.w_rb  = w;
    bus.acc   = acc;
    bus.wdata = d;
    bus.req   = 1'b1;
    #1 check({tag, "_fault"}, 32'(bus.fault), 32'h1);
    tick();
    bus_idle();
    check({tag, "_noresp"}, 32'(bus.resp), 32'h0);
  endtask

  // Lines were raised this cycle (cycle 0); trigger must rise in cycle 3.
  task automatic rise_in3(input string tag);
    tick();
    from = 8'h00;
    check({tag, "_c1"}, 32'(trig), 32'h0);
    tick();
    check({tag, "_c2"}, 32'(trig), 32'h0);
    tick();
    check({tag, "_c3"}, 32'(trig), 32'h1);
  endtask

  // Called in the cycle after handled/enable-write resp; trigger must rise 2 cycles later.
  task automatic rise_in2(input string tag);
    tick();
    check({tag, "_gap"}, 32'(trig), 32'h0);
    tick();
    check({tag, "_rise"}, 32'(trig), 32'h1);
  endtask

  task automatic claim_and_handle(input logic [3:0] id, input string tag);
    bus_read(A_CLAIM, 32'h8000_0000 | 32'(id), {tag, "_claim"});
    handled = 1'b1;
    tick();
    handled = 1'b0;
    check({tag, "_drop"}, 32'(trig), 32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    from    = 8'h00;
    handled = 1'b0;
    bus_idle();
    tick();
    tick();
    check("rst_trig",  32'(trig), 32'h0);
    check("rst_resp",  32'(bus.resp), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    tick();
    bus_read(A_PEND,  32'h0, "rst_pend");
    bus_read(A_EN,    32'h0, "rst_en");
    bus_read(A_PRIO,  32'h0, "rst_prio");
    bus_read(A_CLAIM, 32'h0, "rst_claim");

    // Single source end-to-end
    bus_write(A_EN, 32'h01);
    from = 8'h01;
    rise_in3("t1");
    claim_and_handle(4'd0, "t1");
    bus_read(A_PEND, 32'h0, "t1_pend");

    // Priority order with a tie between sources 2 and 5
    bus_write(A_PRIO, 32'h0000_0C34);
    bus_read(A_PRIO, 32'h0000_0C34, "t2_prio");
    bus_write(A_EN, 32'hFF);
    from = 8'h26;
    rise_in3("t2a");
    claim_and_handle(4'd2, "t2a");
    rise_in2("t2b");
    claim_and_handle(4'd5, "t2b");
    rise_in2("t2c");
    claim_and_handle(4'd1, "t2c");
    bus_read(A_PEND, 32'h0, "t2_pend");

    // Pending latched while disabled, released by enable write
    bus_write(A_EN, 32'h00);
    from = 8'h10;
    tick();
    from = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("t3_masked", 32'(trig), 32'h0);
      tick();
    end
    bus_read(A_PEND, 32'h10, "t3_pend");
    bus_write(A_EN, 32'h10);
    rise_in2("t3");
    claim_and_handle(4'd4, "t3");

    // Software withdraw by W1C on the winner's pending bit
    bus_write(A_EN, 32'h08);
    from = 8'h08;
    rise_in3("t4a");
    bus_write(A_PEND, 32'h08);
    check("t4a_hold", 32'(trig), 32'h1);
    tick();
    check("t4a_withdraw", 32'(trig), 32'h0);
    bus_read(A_CLAIM, 32'h0000_0003, "t4a_claim_idle");
    bus_read(A_PEND, 32'h0, "t4a_pend");

    // New edge in the same cycle as handled keeps the bit pending
    from = 8'h08;
    rise_in3("t4b");
    from    = 8'h08;
    handled = 1'b1;
    tick();
    from    = 8'h00;
    handled = 1'b0;
    check("t4b_drop", 32'(trig), 32'h0);
    rise_in2("t4b");
    claim_and_handle(4'd3, "t4b");
    bus_read(A_PEND, 32'h0, "t4b_pend");

    // Illegal accesses leave state untouched
    bus_fault(A_EN,    1'b0, `BUS_ACC_1B, 32'h0,  "t5_acc1b");
    bus_fault(4'h6,    1'b0, `BUS_ACC_4B, 32'h0,  "t5_misalign");
    bus_fault(A_CLAIM, 1'b1, `BUS_ACC_4B, 32'hFF, "t5_wrclaim");
    bus_fault(A_EN,    1'b1, `BUS_ACC_2B, 32'hFF, "t5_wr2b");
    bus_fault(4'h1,    1'b1, `BUS_ACC_4B, 32'hFF, "t5_wrmis");
    bus_read(A_EN,   32'h08,        "t5_en");
    bus_read(A_PRIO, 32'h0000_0C34, "t5_prio");

    // Reset while signalling
    from = 8'h08;
    rise_in3("t6");
    rst = 1'b1;
    tick();
    check("t6_trig",  32'(trig), 32'h0);
    check("t6_resp",  32'(bus.resp), 32'h0);
    check("t6_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    tick();
    check("t6_idle", 32'(trig), 32'h0);
    bus_read(A_EN,    32'h0, "t6_en");
    bus_read(A_PEND,  32'h0, "t6_pend");
    bus_read(A_PRIO,  32'h0, "t6_prio");
    bus_read(A_CLAIM, 32'h0, "t6_claim");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
